// File: rtl/mdio_slave.sv
// Clause 22 MDIO responder: oversamples MDC/MDIO on clk, decodes frames and
// maps each access onto a single-cycle register-bank strobe.
module mdio_slave #(
  parameter logic [4:0]  PHY_ADDRESS   = 5'h0c,
  parameter int unsigned PREAMBLE_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        reg_rd_en,
  output logic        reg_wr_en,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wr_data,
  input  logic [15:0] reg_rd_data,
  output logic        frame_error
);

  localparam int PW = (PREAMBLE_BITS > 0) ? $clog2(PREAMBLE_BITS + 1) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_BITS);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_OPCODE, ST_PHYAD, ST_REGAD, ST_IGNORE,
    ST_TA_READ, ST_READ_DATA, ST_TA_WRITE, ST_WRITE_DATA
  } state_t;

  logic mdc_s1_q, mdc_s2_q, mdc_prev_q, mdio_s1_q, mdio_s2_q;
  logic mdc_rise, bit_in;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_cnt_q, pre_cnt_d, pre_inc;
  logic            pre_sat;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      phyad_q, phyad_d;
  logic [15:0]     shift_q, shift_d;
  logic            ta_bad_q, ta_bad_d;
  logic            rd_cap_q, rd_cap_d;
  logic            mdio_o_q, mdio_o_d, mdio_t_q, mdio_t_d;
  logic            reg_rd_en_q, reg_rd_en_d, reg_wr_en_q, reg_wr_en_d;
  logic [4:0]      reg_addr_q, reg_addr_d;
  logic [15:0]     reg_wr_data_q, reg_wr_data_d;
  logic            frame_error_q, frame_error_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      mdc_s1_q   <= 1'b0;
      mdc_s2_q   <= 1'b0;
      mdc_prev_q <= 1'b0;
      mdio_s1_q  <= 1'b0;
      mdio_s2_q  <= 1'b0;
    end else begin
      mdc_s1_q   <= mdc;
      mdc_s2_q   <= mdc_s1_q;
      mdc_prev_q <= mdc_s2_q;
      mdio_s1_q  <= mdio_i;
      mdio_s2_q  <= mdio_s1_q;
    end
  end

  assign mdc_rise = mdc_s2_q & ~mdc_prev_q;
  assign bit_in   = mdio_s2_q;
  assign pre_sat  = (pre_cnt_q >= PRE_MAX);
  assign pre_inc  = pre_sat ? pre_cnt_q : pre_cnt_q + PW'(1);

  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    op_d          = op_q;
    phyad_d       = phyad_q;
    shift_d       = shift_q;
    ta_bad_d      = ta_bad_q;
    mdio_o_d      = mdio_o_q;
    mdio_t_d      = mdio_t_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    reg_rd_en_d   = 1'b0;
    reg_wr_en_d   = 1'b0;
    frame_error_d = 1'b0;
    rd_cap_d      = reg_rd_en_q;

    if (mdc_rise) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bit_in)       pre_cnt_d = pre_inc;
          else if (pre_sat) state_d   = ST_START;
          else              pre_cnt_d = '0;
        end
        ST_START: begin
          if (bit_in) begin
            state_d   = ST_OPCODE;
            bit_cnt_d = 4'd1;
          end else begin
            state_d   = ST_IDLE;
            pre_cnt_d = '0;
          end
        end
        ST_OPCODE: begin
          op_d = {op_q[0], bit_in};
          if (bit_cnt_q == 4'd0) begin
            state_d   = ST_PHYAD;
            bit_cnt_d = 4'd4;
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end
        ST_PHYAD: begin
          phyad_d = {phyad_q[3:0], bit_in};
          if (bit_cnt_q == 4'd0) begin
            state_d   = ST_REGAD;
            bit_cnt_d = 4'd4;
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end
        ST_REGAD: begin
          reg_addr_d = {reg_addr_q[3:0], bit_in};
          if (bit_cnt_q == 4'd0) begin
            pre_cnt_d = '0;
            bit_cnt_d = 4'd1;
            if (phyad_q != PHY_ADDRESS) begin
              state_d = (PREAMBLE_BITS == 0) ? ST_IDLE : ST_IGNORE;
            end else if (op_q == 2'b10) begin
              reg_rd_en_d = 1'b1;
              state_d     = ST_TA_READ;
            end else if (op_q == 2'b01) begin
              state_d = ST_TA_WRITE;
            end else begin
              frame_error_d = 1'b1;
              state_d       = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end
        // Foreign frame: stay deaf until a fresh preamble run has been seen.
        ST_IGNORE: begin
          if (bit_in) begin
            pre_cnt_d = pre_inc;
            if (pre_inc >= PRE_MAX) state_d = ST_IDLE;
          end else begin
            pre_cnt_d = '0;
          end
        end
        ST_TA_READ: begin
          if (bit_cnt_q != 4'd0) begin
            mdio_t_d  = 1'b0;
            mdio_o_d  = 1'b0;
            bit_cnt_d = bit_cnt_q - 4'd1;
          end else begin
            mdio_o_d  = shift_q[15];
            shift_d   = {shift_q[14:0], 1'b0};
            bit_cnt_d = 4'd15;
            state_d   = ST_READ_DATA;
          end
        end
        ST_READ_DATA: begin
          if (bit_cnt_q != 4'd0) begin
            mdio_o_d  = shift_q[15];
            shift_d   = {shift_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 4'd1;
          end else begin
            mdio_t_d  = 1'b1;
            mdio_o_d  = 1'b0;
            pre_cnt_d = '0;
            state_d   = ST_IDLE;
          end
        end
        ST_TA_WRITE: begin
          if (bit_cnt_q != 4'd0) begin
            ta_bad_d  = ~bit_in;
            bit_cnt_d = bit_cnt_q - 4'd1;
          end else if (ta_bad_q || bit_in) begin
            frame_error_d = 1'b1;
            pre_cnt_d     = '0;
            state_d       = ST_IDLE;
          end else begin
            bit_cnt_d = 4'd15;
            state_d   = ST_WRITE_DATA;
          end
        end
        ST_WRITE_DATA: begin
          shift_d = {shift_q[14:0], bit_in};
          if (bit_cnt_q == 4'd0) begin
            reg_wr_data_d = {shift_q[14:0], bit_in};
            reg_wr_en_d   = 1'b1;
            pre_cnt_d     = '0;
            state_d       = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          pre_cnt_d = '0;
        end
      endcase
    end

    // Read data arrives the clk after the strobe; MDC is far too slow to collide.
    if (rd_cap_q) shift_d = reg_rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pre_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      op_q          <= '0;
      phyad_q       <= '0;
      shift_q       <= '0;
      ta_bad_q      <= 1'b0;
      rd_cap_q      <= 1'b0;
      mdio_o_q      <= 1'b0;
      mdio_t_q      <= 1'b1;
      reg_rd_en_q   <= 1'b0;
      reg_wr_en_q   <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      op_q          <= op_d;
      phyad_q       <= phyad_d;
      shift_q       <= shift_d;
      ta_bad_q      <= ta_bad_d;
      rd_cap_q      <= rd_cap_d;
      mdio_o_q      <= mdio_o_d;
      mdio_t_q      <= mdio_t_d;
      reg_rd_en_q   <= reg_rd_en_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign mdio_o      = mdio_o_q;
  assign mdio_t      = mdio_t_q;
  assign reg_rd_en   = reg_rd_en_q;
  assign reg_wr_en   = reg_wr_en_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_mdio_slave.sv
// Bench for mdio_slave: a bit-level MDIO master drives frames; a scoreboard
// matches register-port strobes against expected events queued by stimulus.
`timescale 1ns/1ps
module tb_mdio_slave;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic mdc_a = 1'b0, mdc_b = 1'b0;
  logic m_oe = 1'b0, m_val = 1'b1;
  logic [15:0] rd_value = 16'h0000;

  logic a_o, a_t, a_rd, a_wr, a_err, b_o, b_t, b_rd, b_wr, b_err;
  logic [4:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic line_a, line_b;

  // Open-drain style line with pull-up when nobody drives.
  assign line_a = a_t ? (m_oe ? m_val : 1'b1) : a_o;
  assign line_b = b_t ? (m_oe ? m_val : 1'b1) : b_o;

  mdio_slave #(.PHY_ADDRESS(5'h0c), .PREAMBLE_BITS(32)) dut_a (
    .clk(clk), .reset(reset), .mdc(mdc_a), .mdio_i(line_a),
    .mdio_o(a_o), .mdio_t(a_t), .reg_rd_en(a_rd), .reg_wr_en(a_wr),
    .reg_addr(a_addr), .reg_wr_data(a_wdata), .reg_rd_data(rd_value),
    .frame_error(a_err));

  mdio_slave #(.PHY_ADDRESS(5'h0c), .PREAMBLE_BITS(0)) dut_b (
    .clk(clk), .reset(reset), .mdc(mdc_b), .mdio_i(line_b),
    .mdio_o(b_o), .mdio_t(b_t), .reg_rd_en(b_rd), .reg_wr_en(b_wr),
    .reg_addr(b_addr), .reg_wr_data(b_wdata), .reg_rd_data(rd_value),
    .frame_error(b_err));

  typedef struct {
    int          dut;
    int          kind;   // 0 read strobe, 1 write strobe, 2 frame error
    logic [4:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int t_low_a = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int dut, input int kind, input logic [4:0] addr, input logic [15:0] data);
    ev_t e;
    e.dut = dut; e.kind = kind; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int d, input logic rd, input logic wr, input logic err,
                         input logic [4:0] addr, input logic [15:0] wd);
    ev_t e;
    int kind;
    if (rd || wr || err) begin
      check("single_strobe", int'(rd) + int'(wr) + int'(err), 1);
      kind = rd ? 0 : (wr ? 1 : 2);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: dut %0d kind %0d addr %0h data %0h, none expected", d, kind, addr, wd);
      end else begin
        e = exp_q.pop_front();
        check("ev_dut", d, e.dut);
        check("ev_kind", kind, e.kind);
        if (kind != 2) check("ev_addr", addr, e.addr);
        if (kind == 1) check("ev_wdata", wd, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      observe(0, a_rd, a_wr, a_err, a_addr, a_wdata);
      observe(1, b_rd, b_wr, b_err, b_addr, b_wdata);
    end
    if (!a_t) t_low_a <= t_low_a + 1;
  end

  task automatic set_mdc(input int sel, input logic v);
    if (sel == 0) mdc_a = v; else mdc_b = v;
  endtask

  task automatic drive_bit(input int sel, input logic b);
    m_oe = 1'b1;
    m_val = b;
    #80 set_mdc(sel, 1'b1);
    #80 set_mdc(sel, 1'b0);
  endtask

  task automatic do_frame(input int sel, input int npre, input logic [1:0] op,
                          input logic [4:0] phy, input logic [4:0] ra, input logic [1:0] ta,
                          input logic [15:0] wd, input bit chk_read, input int abort_k,
                          input int ntail, output logic [15:0] rdata);
    logic [13:0] hdr;
    logic s_line, s_t;
    hdr = {2'b01, op, phy, ra};
    rdata = 16'h0000;
    for (int i = 0; i < npre; i++) drive_bit(sel, 1'b1);
    for (int i = 13; i >= 0; i--) drive_bit(sel, hdr[i]);
    if (op == 2'b10) begin
      m_oe = 1'b0;
      for (int k = 0; k < 18; k++) begin
        #80 set_mdc(sel, 1'b1);
        if (k == abort_k) begin
          #40;
          @(negedge clk) reset = 1'b1;
          @(posedge clk);
          #1 check("reset_release_t", (sel == 0) ? a_t : b_t, 1'b1);
          @(negedge clk) reset = 1'b0;
          #40 set_mdc(sel, 1'b0);
          return;
        end
        #75;
        s_line = (sel == 0) ? line_a : line_b;
        s_t    = (sel == 0) ? a_t : b_t;
        if (k >= 1 && k <= 16) rdata = {rdata[14:0], s_line};
        if (chk_read && k == 0) begin
          check("ta_drive_t", s_t, 1'b0);
          check("ta_zero", s_line, 1'b0);
        end
        if (chk_read && k == 17) check("release_after_d0", s_t, 1'b1);
        #5 set_mdc(sel, 1'b0);
      end
    end else begin
      drive_bit(sel, ta[1]);
      drive_bit(sel, ta[0]);
      for (int i = 15; i >= 0; i--) drive_bit(sel, wd[i]);
    end
    m_oe = 1'b0;
    for (int i = 0; i < ntail; i++) begin
      #80 set_mdc(sel, 1'b1);
      #80 set_mdc(sel, 1'b0);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running at %0t, limit 3ms", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    int s;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mdio_t", a_t, 1'b1);
    check("rst_mdio_o", a_o, 1'b0);
    check("rst_rd_en", a_rd, 1'b0);
    check("rst_wr_en", a_wr, 1'b0);
    check("rst_addr", a_addr, 5'h00);
    check("rst_wdata", a_wdata, 16'h0000);
    check("rst_ferr", a_err, 1'b0);
    check("rst_b_mdio_t", b_t, 1'b1);
    @(negedge clk) reset = 1'b0;
    repeat (4) @(posedge clk);

    // Short preamble (31 ones) straight after reset: must be ignored.
    rd_value = 16'h1111;
    s = t_low_a;
    do_frame(0, 31, 2'b10, 5'h0c, 5'h02, 2'b00, 16'h0000, 1'b0, -1, 2, r);
    check("short_pre_rdata", r, 16'hFFFF);
    check("short_pre_t_held", t_low_a - s, 0);

    // Plain read.
    rd_value = 16'hA5C3;
    push(0, 0, 5'h02, 16'h0000);
    do_frame(0, 32, 2'b10, 5'h0c, 5'h02, 2'b00, 16'h0000, 1'b1, -1, 2, r);
    check("read_rdata", r, 16'hA5C3);

    // Plain write; the line must never be driven by the slave.
    push(0, 1, 5'h1f, 16'h8000);
    s = t_low_a;
    do_frame(0, 32, 2'b01, 5'h0c, 5'h1f, 2'b10, 16'h8000, 1'b0, -1, 2, r);
    check("write_t_held", t_low_a - s, 0);

    // Foreign PHY address.
    s = t_low_a;
    do_frame(0, 32, 2'b10, 5'h05, 5'h02, 2'b00, 16'h0000, 1'b0, -1, 2, r);
    check("foreign_rdata", r, 16'hFFFF);
    check("foreign_t_held", t_low_a - s, 0);

    // Preamble suppression, then back-to-back write and read with no gap.
    rd_value = 16'h1234;
    push(1, 0, 5'h04, 16'h0000);
    do_frame(1, 0, 2'b10, 5'h0c, 5'h04, 2'b00, 16'h0000, 1'b1, -1, 0, r);
    check("nopre_rdata", r, 16'h1234);
    push(1, 1, 5'h09, 16'hBEEF);
    do_frame(1, 0, 2'b01, 5'h0c, 5'h09, 2'b10, 16'hBEEF, 1'b0, -1, 0, r);
    rd_value = 16'h00FF;
    push(1, 0, 5'h0a, 16'h0000);
    do_frame(1, 0, 2'b10, 5'h0c, 5'h0a, 2'b00, 16'h0000, 1'b1, -1, 2, r);
    check("b2b_rdata", r, 16'h00FF);

    // Bad turnaround on a write, then an illegal opcode followed by a good read.
    push(0, 2, 5'h00, 16'h0000);
    do_frame(0, 32, 2'b01, 5'h0c, 5'h1f, 2'b11, 16'h5555, 1'b0, -1, 2, r);
    push(0, 2, 5'h00, 16'h0000);
    do_frame(0, 32, 2'b11, 5'h0c, 5'h03, 2'b10, 16'h1234, 1'b0, -1, 2, r);
    rd_value = 16'h0F0F;
    push(0, 0, 5'h07, 16'h0000);
    do_frame(0, 32, 2'b10, 5'h0c, 5'h07, 2'b00, 16'h0000, 1'b1, -1, 2, r);
    check("post_err_rdata", r, 16'h0F0F);

    // Reset while D7 is on the line, then a clean read.
    rd_value = 16'hC0DE;
    push(0, 0, 5'h05, 16'h0000);
    do_frame(0, 32, 2'b10, 5'h0c, 5'h05, 2'b00, 16'h0000, 1'b1, 9, 0, r);
    repeat (20) @(posedge clk);
    rd_value = 16'h3C5A;
    push(0, 0, 5'h03, 16'h0000);
    do_frame(0, 32, 2'b10, 5'h0c, 5'h03, 2'b00, 16'h0000, 1'b1, -1, 2, r);
    check("post_reset_rdata", r, 16'h3C5A);

    repeat (50) @(posedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
